alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational alu instance among NumReq requesters, such as decode, address generation and a debug port. Arbitration is round-robin, and each requester uses a valid/ready request handshake. The ALU output is captured in a single response register, which presents the result, flags and the winning requester's ID on one shared response channel with backpressure. The block sits between the requesting pipeline stages and the ALU datapath.

Parameters:
NumReq, 4, number of requesters; legal range 2..8.
IdWidth, $clog2(NumReq), derived localparam; width of RspId.

Ports:
Clock  input  1  single clock; all state updates on the rising edge.
ResetN  input  1  asynchronous, active-low reset.
ReqValid  input  NumReq  per-requester request valid.
ReqReady  output  NumReq  per-requester accept; at most one bit is high in any cycle.
ReqOperation  input  NumReq*3  packed; slice i is requester i's 3-bit ALU opcode.
ReqOperand1  input  NumReq*16  packed; slice i is requester i's first operand.
ReqOperand2  input  NumReq*16  packed; slice i is requester i's second operand.
RspValid  output  1  response register holds a valid result.
RspReady  input  1  consumer accepts the response.
RspId  output  IdWidth  index of the requester that produced the response.
RspResult  output  16  registered ALU Result.
RspFlags  output  4  registered ALU Flags, ordered {UnsignedOverflow, SignedOverflow, Negative, Zero}.

Behaviour:
- Reset (ResetN low, asynchronous):
  - RspValid=0, RspId=0, RspResult=16'h0000, RspFlags=4'h0.
  - LastGrant=NumReq-1, so requester 0 has highest priority after reset.
  - Any held response is dropped.
- Accept condition: StageFree = ~RspValid | RspReady.
- Grant (combinational):
  - Search ReqValid starting at LastGrant+1 mod NumReq, wrapping; the first set bit wins.
  - ReqReady[g] = StageFree & ReqValid[g]; all other ReqReady bits are 0.
  - If no ReqValid bit is set, all ReqReady bits are 0.
- Handshake rules:
  - A transfer occurs when ReqValid[i] & ReqReady[i].
  - Requesters hold valid and payload stable until accepted.
  - Requesters must not make ReqValid depend on ReqReady.
  - ReqReady may depend combinationally on ReqValid and RspReady.
- Datapath:
  - The winner's opcode and operands are muxed into the alu instance.
  - On transfer, the response register loads Result, Flags and the winner's ID, RspValid is set to 1, and LastGrant is set to the winner.
- Latency and throughput:
  - Exactly 1 cycle: a request accepted at edge N is visible on the response outputs after edge N.
  - Throughput is 1 operation per cycle while RspReady=1.
- Response retirement:
  - If RspValid & RspReady and there is no new transfer, RspValid clears on the next edge.
  - If RspValid & RspReady and there is a simultaneous new transfer, the register reloads with the new response and RspValid stays 1 (no bubble).
- Backpressure: while RspValid & ~RspReady, RspId, RspResult and RspFlags are held stable, all ReqReady bits are 0, and LastGrant is unchanged.
- Arithmetic: opcode semantics and flag generation are exactly those of alu; this block performs no arithmetic itself.
- Fairness: any continuously-valid requester is granted within NumReq accepted transfers.
- Boundary behaviour:
  - The LastGrant wrap from NumReq-1 to 0 is handled by the modulo search.
  - With a single active requester, that requester is granted every cycle.
  - Deasserting ResetN mid-operation loses the in-flight response; no partial state survives.

Decomposition:
- Package alu_pkg:
  - AluOp enum (3-bit): ADD=0, SUB=1, SHL=2, SHR=3, SRA=4, AND=5, OR=6, XOR=7.
  - AluFlags packed struct {UnsignedOverflow, SignedOverflow, Negative, Zero}.
  - Flag bit-index constants.
  - The alu module adopts alu_pkg.
- Sub-module rr_arbiter (parameter NumReq):
  - Inputs: Requests, Advance, Clock, ResetN.
  - Outputs: one-hot Grant and binary GrantId.
  - Owns the LastGrant register.
- alu_arbiter contains the operand mux, the alu instance and the response register.

Test Plan:
1. Requester 0 sends ADD 16'hFFFF+16'h0001 with RspReady=1 -> one cycle later: RspValid=1, RspId=0, RspResult=16'h0000, RspFlags=4'b1001.
2. All 4 requesters continuously valid with RspReady=1 -> RspId sequence is 0,1,2,3,0,1 on consecutive cycles; exactly one ReqReady bit is high per cycle.
3. Requester 2 sends XOR 16'h00FF^16'h00FF, then RspReady is held 0 for 3 cycles -> RspResult=16'h0000 and RspFlags=4'b0001 are held stable, and ReqReady=4'b0000. When RspReady rises, the next pending request is accepted in that same cycle.
4. Only requester 3 is valid, issuing 5 back-to-back OR ops (16'h0F00|16'h00F0 and so on) -> 5 responses on 5 consecutive cycles, all with RspId=3 and no bubbles.
5. ResetN is pulled low while RspValid=1 -> RspValid goes to 0 immediately, before the next Clock edge. After release, with requesters 1 and 0 both valid, requester 0 is granted first.
6. Requesters 1 and 3 are valid while LastGrant=3 -> requester 1 is granted, then requester 3, then requester 1 (wrap-around order verified).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, flag layout and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SHL = 3'd2,
        SHR = 3'd3,
        SRA = 3'd4,
        AND = 3'd5,
        OR  = 3'd6,
        XOR = 3'd7
    } AluOp;

    typedef struct packed {
        logic unsigned_ovf;
        logic signed_ovf;
        logic negative;
        logic zero;
    } AluFlags;

    localparam int FLAG_ZERO         = 0;
    localparam int FLAG_NEGATIVE     = 1;
    localparam int FLAG_SIGNED_OVF   = 2;
    localparam int FLAG_UNSIGNED_OVF = 3;

endpackage

// File: rtl/alu.sv
// 16-bit combinational ALU; shifts use operand b[3:0] as the shift amount.
module alu
    import alu_pkg::*;
(
    input  AluOp        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output AluFlags     flags
);

    logic [16:0] wide;

    always_comb begin
        wide  = 17'd0;
        flags = '0;
        unique case (op)
            ADD: begin
                wide              = {1'b0, a} + {1'b0, b};
                flags.unsigned_ovf = wide[16];
                flags.signed_ovf   = (a[15] == b[15]) && (wide[15] != a[15]);
            end
            SUB: begin
                // Unsigned overflow on subtract is the borrow out.
                wide              = {1'b0, a} - {1'b0, b};
                flags.unsigned_ovf = wide[16];
                flags.signed_ovf   = (a[15] != b[15]) && (wide[15] != a[15]);
            end
            SHL:     wide = {1'b0, a << b[3:0]};
            SHR:     wide = {1'b0, a >> b[3:0]};
            SRA:     wide = {1'b0, $signed(a) >>> b[3:0]};
            AND:     wide = {1'b0, a & b};
            OR:      wide = {1'b0, a | b};
            default: wide = {1'b0, a ^ b};
        endcase
        result         = wide[15:0];
        flags.negative = result[15];
        flags.zero     = (result == 16'h0000);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
    parameter  int NumReq  = 4,
    localparam int IdWidth = $clog2(NumReq)
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [NumReq-1:0]  Requests,
    input  logic               Advance,
    output logic [NumReq-1:0]  Grant,
    output logic [IdWidth-1:0] GrantId
);

    logic [IdWidth-1:0] last_grant;
    logic [IdWidth-1:0] idx;
    logic               found;

    always_comb begin
        Grant   = '0;
        GrantId = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = IdWidth'((int'(last_grant) + k) % NumReq);
            if (!found && Requests[idx]) begin
                found      = 1'b1;
                Grant[idx] = 1'b1;
                GrantId    = idx;
            end
        end
    end

    // Reset to the top index so requester 0 wins first.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)
            last_grant <= IdWidth'(NumReq - 1);
        else if (Advance)
            last_grant <= GrantId;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NumReq requesters; result lands in a single response register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NumReq  = 4,
    localparam int IdWidth = $clog2(NumReq)
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [NumReq-1:0]    ReqValid,
    output logic [NumReq-1:0]    ReqReady,
    input  logic [NumReq*3-1:0]  ReqOperation,
    input  logic [NumReq*16-1:0] ReqOperand1,
    input  logic [NumReq*16-1:0] ReqOperand2,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [IdWidth-1:0]   RspId,
    output logic [15:0]          RspResult,
    output logic [3:0]           RspFlags
);

    logic               stage_free;
    logic               xfer;
    logic [NumReq-1:0]  grant;
    logic [IdWidth-1:0] grant_id;
    logic [2:0]         op_bits;
    logic [15:0]        opa, opb, result;
    AluFlags            flags;

    assign stage_free = ~RspValid | RspReady;
    assign xfer       = stage_free & (|ReqValid);
    assign ReqReady   = stage_free ? grant : '0;

    rr_arbiter #(.NumReq(NumReq)) u_arb (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Requests (ReqValid),
        .Advance  (xfer),
        .Grant    (grant),
        .GrantId  (grant_id)
    );

    // One-hot grant selects the winner's payload.
    always_comb begin
        op_bits = 3'd0;
        opa     = 16'h0000;
        opb     = 16'h0000;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                op_bits = ReqOperation[i*3 +: 3];
                opa     = ReqOperand1[i*16 +: 16];
                opb     = ReqOperand2[i*16 +: 16];
            end
        end
    end

    alu u_alu (
        .op     (AluOp'(op_bits)),
        .a      (opa),
        .b      (opb),
        .result (result),
        .flags  (flags)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            RspValid  <= 1'b0;
            RspId     <= '0;
            RspResult <= 16'h0000;
            RspFlags  <= 4'h0;
        end else if (xfer) begin
            RspValid  <= 1'b1;
            RspId     <= grant_id;
            RspResult <= result;
            RspFlags  <= flags;
        end else if (RspReady) begin
            RspValid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshake, round-robin order, backpressure, reset.
module tb_alu_arbiter;

    localparam int N = 4;

    logic          Clock, ResetN;
    logic [N-1:0]  ReqValid, ReqReady;
    logic [N*3-1:0]  ReqOperation;
    logic [N*16-1:0] ReqOperand1, ReqOperand2;
    logic          RspValid, RspReady;
    logic [1:0]    RspId;
    logic [15:0]   RspResult;
    logic [3:0]    RspFlags;

    int n_asrt = 0;
    int n_fail = 0;

    alu_arbiter #(.NumReq(N)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqOperation (ReqOperation),
        .ReqOperand1  (ReqOperand1),
        .ReqOperand2  (ReqOperand2),
        .RspValid     (RspValid),
        .RspReady     (RspReady),
        .RspId        (RspId),
        .RspResult    (RspResult),
        .RspFlags     (RspFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        ReqOperation[i*3 +: 3] = op;
        ReqOperand1[i*16 +: 16] = a;
        ReqOperand2[i*16 +: 16] = b;
    endtask

    logic [1:0] exp_id [6];
    logic [1:0] rr6 [3];

    initial begin
        ResetN = 1'b0; ReqValid = '0; RspReady = 1'b1;
        ReqOperation = '0; ReqOperand1 = '0; ReqOperand2 = '0;
        #1;
        chk("rst_valid",  {31'd0, RspValid}, 32'd0);
        chk("rst_id",     {30'd0, RspId}, 32'd0);
        chk("rst_result", {16'd0, RspResult}, 32'd0);
        chk("rst_flags",  {28'd0, RspFlags}, 32'd0);
        step(); step();
        ResetN = 1'b1;
        step();

        // T1: ADD FFFF+0001 from requester 0
        set_req(0, 3'd0, 16'hFFFF, 16'h0001);
        ReqValid = 4'b0001;
        #1 chk("t1_ready", {28'd0, ReqReady}, 32'h1);
        step();
        ReqValid = '0;
        chk("t1_valid",  {31'd0, RspValid}, 32'd1);
        chk("t1_id",     {30'd0, RspId}, 32'd0);
        chk("t1_result", {16'd0, RspResult}, 32'h0000);
        chk("t1_flags",  {28'd0, RspFlags}, 32'b1001);
        step();
        chk("t1_retire", {31'd0, RspValid}, 32'd0);

        // T4: requester 3 alone, five back-to-back ORs
        ReqValid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            set_req(3, 3'd6, 16'h0F00 | 16'(k), 16'h00F0);
            #1 chk("t4_ready", {28'd0, ReqReady}, 32'b1000);
            step();
            chk("t4_valid",  {31'd0, RspValid}, 32'd1);
            chk("t4_id",     {30'd0, RspId}, 32'd3);
            chk("t4_result", {16'd0, RspResult}, 32'h0FF0 + k);
            chk("t4_flags",  {28'd0, RspFlags}, 32'd0);
        end
        ReqValid = '0;
        step();
        chk("t4_retire", {31'd0, RspValid}, 32'd0);

        // T2: all four valid, LastGrant=3 -> 0,1,2,3,0,1
        for (int i = 0; i < N; i++) set_req(i, 3'd0, 16'h0100 * 16'(i), 16'h0005);
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
        exp_id[3] = 2'd3; exp_id[4] = 2'd0; exp_id[5] = 2'd1;
        ReqValid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1 chk("t2_ready", {28'd0, ReqReady}, 32'd1 << exp_id[c]);
            step();
            chk("t2_id",     {30'd0, RspId}, {30'd0, exp_id[c]});
            chk("t2_result", {16'd0, RspResult}, 32'h0005 + 32'h0100 * exp_id[c]);
        end
        ReqValid = '0;
        step();
        chk("t2_retire", {31'd0, RspValid}, 32'd0);

        // T3: requester 2 XOR, then backpressure with requester 3 pending
        set_req(2, 3'd7, 16'h00FF, 16'h00FF);
        ReqValid = 4'b0100;
        RspReady = 1'b0;
        #1 chk("t3_ready", {28'd0, ReqReady}, 32'b0100);
        step();
        chk("t3_valid", {31'd0, RspValid}, 32'd1);
        chk("t3_id",    {30'd0, RspId}, 32'd2);
        set_req(3, 3'd1, 16'h0003, 16'h0005);
        ReqValid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t3_bp_ready", {28'd0, ReqReady}, 32'd0);
            step();
            chk("t3_bp_valid",  {31'd0, RspValid}, 32'd1);
            chk("t3_bp_id",     {30'd0, RspId}, 32'd2);
            chk("t3_bp_result", {16'd0, RspResult}, 32'h0000);
            chk("t3_bp_flags",  {28'd0, RspFlags}, 32'b0001);
        end
        RspReady = 1'b1;
        #1 chk("t3_release_ready", {28'd0, ReqReady}, 32'b1000);
        step();
        chk("t3_sub_id",     {30'd0, RspId}, 32'd3);
        chk("t3_sub_result", {16'd0, RspResult}, 32'hFFFE);
        chk("t3_sub_flags",  {28'd0, RspFlags}, 32'b1010);

        // T6: requesters 1 and 3 with LastGrant=3 -> 1,3,1
        set_req(1, 3'd5, 16'hFFFF, 16'h1234);
        set_req(3, 3'd2, 16'h0001, 16'h0004);
        rr6[0] = 2'd1; rr6[1] = 2'd3; rr6[2] = 2'd1;
        ReqValid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t6_ready", {28'd0, ReqReady}, 32'd1 << rr6[c]);
            step();
            chk("t6_id",     {30'd0, RspId}, {30'd0, rr6[c]});
            chk("t6_result", {16'd0, RspResult}, (rr6[c] == 2'd1) ? 32'h1234 : 32'h0010);
        end

        // T5: asynchronous reset while a response is held
        chk("t5_pre_valid", {31'd0, RspValid}, 32'd1);
        #2 ResetN = 1'b0;
        #1;
        chk("t5_async_valid",  {31'd0, RspValid}, 32'd0);
        chk("t5_async_result", {16'd0, RspResult}, 32'd0);
        ReqValid = 4'b0011;
        step();
        ResetN = 1'b1;
        #1 chk("t5_ready", {28'd0, ReqReady}, 32'b0001);
        step();
        chk("t5_id",    {30'd0, RspId}, 32'd0);
        chk("t5_valid", {31'd0, RspValid}, 32'd1);
        ReqValid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
